// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher: expands the key once per block, then runs one
// inverse round per clock using the round keys in reverse order.
module aes_decrypt_iter #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     cipher,
    input  logic [Nk*32-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out
);
    // state  | meaning
    // IDLE   | waiting for a block      KEYEXP | build rk[1..10]   ADDKEY | whiten with rk[10]
    // ROUND  | inverse rounds 9..1      FINAL  | last round, rk[0]  DONE   | plaintext offered
    typedef enum logic [2:0] {IDLE, KEYEXP, ADDKEY, ROUND, FINAL, DONE} fsm_t;

    localparam logic [3:0] LAST = 4'(Nr);

    fsm_t         cur, nxt;
    logic [3:0]   r;
    logic [127:0] state;
    logic [127:0] rk [0:10];
    logic [127:0] rk_prev, rk_cur, rk_next, inv_ss, final_val;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] t;
        t = a;
        for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), a);
        return gmul(t, t);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] p, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(p[23:16]) ^ rc, sbox(p[15:8]), sbox(p[7:0]), sbox(p[31:24])};
        w0 = p[127:96] ^ t;
        w1 = p[95:64] ^ w0;
        w2 = p[63:32] ^ w1;
        w3 = p[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Byte 4c+row moves from column (c-row) mod 4 under InvShiftRows.
    function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                o[127 - 8*(4*c + rw) -: 8] = inv_sbox(s[127 - 8*(4*((c - rw + 4) % 4) + rw) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    always_comb begin
        rk_prev = '0;
        rk_cur  = '0;
        for (int i = 0; i < 11; i++) begin
            if (4'(i) == r - 4'd1) rk_prev = rk[i];
            if (4'(i) == r)        rk_cur  = rk[i];
        end
        rk_next   = expand(rk_prev, rcon(r));
        inv_ss    = inv_sub_shift(state);
        final_val = inv_ss ^ rk[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt       = cur;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (cur)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = KEYEXP;
            end
            KEYEXP:  if (r == LAST) nxt = ADDKEY;
            ADDKEY:  nxt = ROUND;
            ROUND:   if (r == 4'd1) nxt = FINAL;
            FINAL:   nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r     <= '0;
            state <= '0;
            out   <= '0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else begin
            case (cur)
                IDLE: if (in_valid) begin
                    state <= cipher;
                    rk[0] <= key;
                    r     <= 4'd1;
                end
                KEYEXP: begin
                    rk[r] <= rk_next;
                    r     <= r + 4'd1;
                end
                ADDKEY: begin
                    state <= state ^ rk[10];
                    r     <= LAST - 4'd1;
                end
                ROUND: begin
                    state <= inv_mix(inv_ss ^ rk_cur);
                    r     <= r - 4'd1;
                end
                FINAL: begin
                    state <= final_val;
                    out   <= final_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter using FIPS-197 vectors: stimulus pushes the
// expected plaintext, a negedge monitor pops and compares on every output handshake.
module tb_aes_decrypt_iter;
    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic         in_ready, out_valid;
    logic [127:0] cipher = '0, key = '0, out;

    aes_decrypt_iter dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cipher(cipher), .key(key), .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    int           n_cmp = 0, n_fail = 0, cyc = 0, hs = 0, acc_prev = 0, acc_last = 0;
    logic         ov_prev = 1'b0;
    logic [127:0] exp_q[$];
    logic [127:0] held;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                acc_prev = acc_last;
                acc_last = cyc + 1;
            end
            if (out_valid && !ov_prev) check("latency", 128'(cyc - acc_last), 128'd21);
            if (out_valid && out_ready) begin
                hs++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", out);
                end else begin
                    check("plaintext", out, exp_q.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic wait_accept(input logic [127:0] p);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) fail_now("accept_timeout");
        else     exp_q.push_back(p);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
        key      = k;
        cipher   = c;
        in_valid = 1'b1;
        wait_accept(p);
        in_valid = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (hs >= n) ok = 1'b1;
        end
        if (!ok) fail_now("handshake_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) fail_now("valid_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out", out, 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_rk10", dut.rk[10], 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FIPS-197 C.1
        issue(K1, C1, P1);
        wait_hs(1);

        // FIPS-197 App. B with round-key probe
        issue(K2, C2, P2);
        wait_valid();
        check("rk10", dut.rk[10], RK10);
        wait_hs(2);

        // Backpressure with input churn
        out_ready = 1'b0;
        issue(K1, C1, P1);
        wait_valid();
        held = out;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            cipher   = {$urandom, $urandom, $urandom, $urandom};
            key      = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("bp_out_stable", out, held);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_hs(3);
        repeat (5) @(negedge clk);
        check("bp_single_hs", 128'(hs), 128'd3);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        key      = K1;
        cipher   = C1;
        in_valid = 1'b1;
        wait_accept(P1);
        key    = K2;
        cipher = C2;
        wait_accept(P2);
        in_valid = 1'b0;
        wait_hs(5);
        check("b2b_spacing", 128'(acc_last - acc_prev), 128'd23);

        // Reset mid-operation at E15
        issue(K1, C1, P1);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'd0);
        check("midrst_out", out, 128'd0);
        check("midrst_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(K1, C1, P1);
        wait_hs(6);

        // Random inputs on every cycle after accept
        issue(K1, C1, P1);
        for (int i = 0; i < 21; i++) begin
            cipher   = {$urandom, $urandom, $urandom, $urandom};
            key      = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        wait_hs(7);

        repeat (5) @(negedge clk);
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        check("total_handshakes", 128'(hs), 128'd7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
